keypad_scan: RTL

Scanning driver for a 4×4 active-low matrix keypad, the input counterpart of the 4-digit seven-segment display driver. Drives one row low at a time, samples and debounces the columns, encodes each press as a hex digit, and shifts digits into a 16-bit value register. The CPU consumes the register as a hex operand entered from the board, with one digit per key press.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_tick_gen.sv | 27 ++
 rtl/keypad_scan.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Imported by keypad_tick_gen and keypad_scan.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  // Index of the lowest active-low column; only meaningful if any is low.
  function automatic logic [1:0] low_col(
    input logic [NUM_COLS-1:0] c
  );
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Row-period prescaler: one-cycle tick every SCAN_DIV clocks.
// Tick is high while the count sits at SCAN_DIV-1.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce and hex value register.
// Define KEYPAD_REPEAT_EN to auto-repeat a held key every REPEAT_SCANS ticks.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col,
  input  logic                clr,
  output logic [NUM_ROWS-1:0] row,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic [15:0]         value
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic                tick;
  logic [NUM_COLS-1:0] col_m_q, col_s_q;
  kp_state_e           st_q, st_d;
  logic [1:0]          r_q, r_d;
  logic [1:0]          c_q, c_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                kv_q;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [15:0]         val_q, val_d;
  logic                evt;
  logic                idle;
  logic [1:0]          hit;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
`else
  logic unused_rep;
  assign unused_rep = REPEAT_SCANS[0];
`endif

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick_o(tick)
  );

  assign idle = (col_s_q == '1);
  assign hit  = low_col(col_s_q);

  always_comb begin
    st_d  = st_q;
    r_d   = r_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    evt   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d = rep_q;
`endif
    if (tick) begin
      unique case (st_q)
        SCAN: begin
          if (idle) begin
            r_d = r_q + 2'd1;
          end else begin
            c_d   = hit;
            cnt_d = CW'(1);
            st_d  = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!idle && hit == c_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DEBOUNCE_SCANS)) begin
              evt  = 1'b1;
              st_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_d = '0;
`endif
            end
          end else begin
            st_d = SCAN;
            r_d  = r_q + 2'd1;
          end
        end
        PRESSED: begin
          if (idle) begin
            cnt_d = CW'(1);
            st_d  = RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_d = rep_q + RW'(1);
            if (rep_d == RW'(REPEAT_SCANS)) begin
              evt   = 1'b1;
              rep_d = '0;
            end
          end
`endif
        end
        RELEASE: begin
          if (idle) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DEBOUNCE_SCANS)) begin
              st_d = SCAN;
              r_d  = r_q + 2'd1;
            end
          end else begin
            st_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
          end
        end
      endcase
    end
  end

  // Code is 4*r + c, i.e. row index in the upper bits.
  always_comb begin
    code_d = code_q;
    if (evt) code_d = {r_q, c_q};
    val_d = val_q;
    if (clr)      val_d = '0;
    else if (evt) val_d = {val_q[11:0], code_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m_q <= '1;
      col_s_q <= '1;
      st_q    <= SCAN;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      code_q  <= '0;
      val_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      col_m_q <= col;
      col_s_q <= col_m_q;
      st_q    <= st_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      kv_q    <= evt;
      code_q  <= code_d;
      val_q   <= val_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign row       = ~(NUM_ROWS'(1) << r_q);
  assign key_valid = kv_q;
  assign key_code  = code_q;
  assign value     = val_q;

endmodule
